// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types, segment constants and BCD time helpers for the RTC monitor
package rtc_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t hr1;
    bcd_t hr0;
    bcd_t min1;
    bcd_t min0;
    bcd_t sec1;
    bcd_t sec0;
  } rtc_time_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_e;

  // Active-low, bit order gfedcba
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  function automatic rtc_time_t rtc_inc(input rtc_time_t t);
    rtc_time_t r;
    r = t;
    if (t.sec0 != 4'd9) begin
      r.sec0 = t.sec0 + 4'd1;
    end else begin
      r.sec0 = 4'd0;
      if (t.sec1 != 4'd5) begin
        r.sec1 = t.sec1 + 4'd1;
      end else begin
        r.sec1 = 4'd0;
        if (t.min0 != 4'd9) begin
          r.min0 = t.min0 + 4'd1;
        end else begin
          r.min0 = 4'd0;
          if (t.min1 != 4'd5) begin
            r.min1 = t.min1 + 4'd1;
          end else begin
            r.min1 = 4'd0;
            if (t.hr1 == 4'd2 && t.hr0 == 4'd3) begin
              r.hr1 = 4'd0;
              r.hr0 = 4'd0;
            end else if (t.hr0 == 4'd9) begin
              r.hr0 = 4'd0;
              r.hr1 = t.hr1 + 4'd1;
            end else begin
              r.hr0 = t.hr0 + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic rtc_in_range(input rtc_time_t t);
    logic ok;
    ok = 1'b1;
    if (t.hr1 > 4'd2) ok = 1'b0;
    if (t.hr1 == 4'd2 && t.hr0 > 4'd3) ok = 1'b0;
    if (t.min1 > 4'd5) ok = 1'b0;
    if (t.sec1 > 4'd5) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - active-low seven-segment pattern to BCD digit with legality flag
module seg7_decode
  import rtc_pkg::*;
(
  input  logic [6:0] seg,
  output bcd_t       digit,
  output logic       legal
);

  always_comb begin
    digit = 4'hF;
    legal = 1'b1;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rtc_seg_monitor.sv
// rtl/rtc_seg_monitor.sv - samples the six display digits after each tick, decodes to BCD
// and checks that successive samples advance by one second
module rtc_seg_monitor
  import rtc_pkg::*;
#(
  parameter int SAMPLE_DLY = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0][6:0]  sev_seg,
  input  logic             tick,
  input  logic             man_sw,
  input  logic             clr_err,
  output logic [23:0]      time_bcd,
  output logic             time_vld,
  output logic             seg_err,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky
);

  localparam logic [3:0] DLY = 4'(SAMPLE_DLY);

  logic [3:0]       dly_cnt_q, dly_cnt_d;
  logic             cap_en;
  logic [5:0][6:0]  cap_seg_q, cap_seg_d;
  logic             cap_vld_q, cap_vld_d;
  bcd_t [5:0]       dec_digs;
  logic [5:0]       dec_legal;
  rtc_time_t        dec_time;
  logic             dec_bad;
  rtc_time_t        time_q, time_d;
  logic             bad_q, bad_d;
  logic             time_vld_q, time_vld_d;
  mon_state_e       state_q, state_d;
  rtc_time_t        prev_q, prev_d;
  logic             store;
  logic             seg_err_q, seg_err_d;
  logic             seq_err_q, seq_err_d;
  logic             err_event;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sticky_q, err_sticky_d;

  for (genvar i = 0; i < 6; i++) begin : g_dec
    seg7_decode u_dec (
      .seg   (cap_seg_q[i]),
      .digit (dec_digs[i]),
      .legal (dec_legal[i])
    );
  end

  assign dec_time = rtc_time_t'(dec_digs);
  assign dec_bad  = !(&dec_legal) || !rtc_in_range(dec_time);

  // A fresh tick always reloads, so the latest tick wins over a pending count
  always_comb begin
    cap_en     = !tick && (dly_cnt_q == 4'd1);
    dly_cnt_d  = tick ? DLY : ((dly_cnt_q != 4'd0) ? dly_cnt_q - 4'd1 : 4'd0);
    cap_seg_d  = cap_en ? sev_seg : cap_seg_q;
    cap_vld_d  = cap_en;
    time_d     = cap_vld_q ? dec_time : time_q;
    bad_d      = cap_vld_q ? dec_bad : bad_q;
    time_vld_d = cap_vld_q;
  end

  always_comb begin
    state_d = state_q;
    if (time_vld_q) begin
      if (man_sw || bad_q) state_d = ST_EMPTY;
      else                 state_d = ST_TRACK;
    end
  end

  always_comb begin
    seg_err_d = 1'b0;
    seq_err_d = 1'b0;
    store     = 1'b0;
    if (time_vld_q && !man_sw) begin
      if (bad_q) begin
        seg_err_d = 1'b1;
      end else begin
        store = 1'b1;
        if (state_q == ST_TRACK && time_q != rtc_inc(prev_q)) seq_err_d = 1'b1;
      end
    end
  end

  // Clear takes effect before a same-cycle error is counted
  always_comb begin
    err_event    = seg_err_d | seq_err_d;
    prev_d       = store ? time_q : prev_q;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q | err_event;
    if (clr_err) begin
      err_cnt_d    = err_event ? ERR_W'(1) : '0;
      err_sticky_d = err_event;
    end else if (err_event && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_cnt_q    <= '0;
      cap_seg_q    <= '0;
      cap_vld_q    <= 1'b0;
      time_q       <= '0;
      bad_q        <= 1'b0;
      time_vld_q   <= 1'b0;
      state_q      <= ST_EMPTY;
      prev_q       <= '0;
      seg_err_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      dly_cnt_q    <= dly_cnt_d;
      cap_seg_q    <= cap_seg_d;
      cap_vld_q    <= cap_vld_d;
      time_q       <= time_d;
      bad_q        <= bad_d;
      time_vld_q   <= time_vld_d;
      state_q      <= state_d;
      prev_q       <= prev_d;
      seg_err_q    <= seg_err_d;
      seq_err_q    <= seq_err_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign time_bcd   = time_q;
  assign time_vld   = time_vld_q;
  assign seg_err    = seg_err_q;
  assign seq_err    = seq_err_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_rtc_seg_monitor.sv
// tb/tb_rtc_seg_monitor.sv - randomized and directed checks of rtc_seg_monitor against a seconds-of-day model
module tb_rtc_seg_monitor;

  logic            clk;
  logic            rst;
  logic [5:0][6:0] sev_seg;
  logic            tick;
  logic            man_sw;
  logic            clr_err;
  logic [23:0]     time_bcd;
  logic            time_vld;
  logic            seg_err;
  logic            seq_err;
  logic [7:0]      err_cnt;
  logic            err_sticky;

  rtc_seg_monitor #(.SAMPLE_DLY(2), .ERR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .sev_seg    (sev_seg),
    .tick       (tick),
    .man_sw     (man_sw),
    .clr_err    (clr_err),
    .time_bcd   (time_bcd),
    .time_vld   (time_vld),
    .seg_err    (seg_err),
    .seq_err    (seq_err),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [6:0] seg_tab [10];
  int n_cmp;
  int n_bad;
  int m_have;
  int m_prev;
  int m_cnt;
  bit m_sticky;

  // Reference: times as seconds-of-day, successor is (s+1) mod 86400
  task automatic model_frame(input int d[6], input bit man, input bit clr,
                             output logic [23:0] eb, output bit es, output bit eq);
    int hh, mm, ss, secs;
    bit bad;
    bad = 0; es = 0; eq = 0; eb = '0;
    for (int i = 0; i < 6; i++) begin
      if (d[i] > 9) begin bad = 1; eb[i*4 +: 4] = 4'hF; end
      else eb[i*4 +: 4] = 4'(d[i]);
    end
    hh = d[5] * 10 + d[4];
    mm = d[3] * 10 + d[2];
    ss = d[1] * 10 + d[0];
    if (hh > 23 || mm > 59 || ss > 59) bad = 1;
    secs = hh * 3600 + mm * 60 + ss;
    if (man) m_have = 0;
    else if (bad) begin es = 1; m_have = 0; end
    else if (m_have == 0) begin m_have = 1; m_prev = secs; end
    else begin eq = (secs != (m_prev + 1) % 86400); m_prev = secs; end
    if (clr) begin m_cnt = (es | eq) ? 1 : 0; m_sticky = es | eq; end
    else if (es | eq) begin if (m_cnt < 255) m_cnt++; m_sticky = 1; end
  endtask

  task automatic secs_digs(input int s, output int d[6]);
    int hh, mm, ss;
    hh = s / 3600; mm = (s / 60) % 60; ss = s % 60;
    d[5] = hh / 10; d[4] = hh % 10; d[3] = mm / 10; d[2] = mm % 10; d[1] = ss / 10; d[0] = ss % 10;
  endtask

  task automatic drive_digs(input int d[6]);
    for (int i = 0; i < 6; i++) sev_seg[i] = (d[i] < 10) ? seg_tab[d[i]] : 7'h7F;
  endtask

  task automatic run_frame(input string nm, input int d[6], input bit man, input bit clr);
    logic [23:0] eb;
    bit es, eq;
    model_frame(d, man, clr, eb, es, eq);
    @(negedge clk); drive_digs(d); man_sw = man; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_cmp++; if (time_vld !== 1'b0) begin n_bad++; $display("FAIL %s early_vld k=%0d got %b want 0", nm, k, time_vld); end
      n_cmp++; if ((seg_err | seq_err) !== 1'b0) begin n_bad++; $display("FAIL %s stray_err k=%0d got %b%b want 00", nm, k, seg_err, seq_err); end
    end
    @(negedge clk); clr_err = clr;
    n_cmp++; if (time_vld !== 1'b1) begin n_bad++; $display("FAIL %s vld got %b want 1", nm, time_vld); end
    n_cmp++; if (time_bcd !== eb) begin n_bad++; $display("FAIL %s time_bcd got %h want %h", nm, time_bcd, eb); end
    @(negedge clk); clr_err = 1'b0;
    n_cmp++; if (time_vld !== 1'b0) begin n_bad++; $display("FAIL %s vld_width got %b want 0", nm, time_vld); end
    n_cmp++; if (seg_err !== es) begin n_bad++; $display("FAIL %s seg_err got %b want %b", nm, seg_err, es); end
    n_cmp++; if (seq_err !== eq) begin n_bad++; $display("FAIL %s seq_err got %b want %b", nm, seq_err, eq); end
    n_cmp++; if (err_cnt !== m_cnt[7:0]) begin n_bad++; $display("FAIL %s err_cnt got %0d want %0d", nm, err_cnt, m_cnt); end
    n_cmp++; if (err_sticky !== m_sticky) begin n_bad++; $display("FAIL %s err_sticky got %b want %b", nm, err_sticky, m_sticky); end
  endtask

  task automatic run_hms(input string nm, input int hh, input int mm, input int ss, input bit man, input bit clr);
    int d[6];
    d[5] = hh / 10; d[4] = hh % 10; d[3] = mm / 10; d[2] = mm % 10; d[1] = ss / 10; d[0] = ss % 10;
    run_frame(nm, d, man, clr);
  endtask

  task automatic check_idle(input string nm);
    n_cmp++; if ({time_vld, seg_err, seq_err, err_sticky} !== 4'b0) begin n_bad++; $display("FAIL %s pulses got %b want 0000", nm, {time_vld, seg_err, seq_err, err_sticky}); end
    n_cmp++; if (time_bcd !== 24'h0 || err_cnt !== 8'h0) begin n_bad++; $display("FAIL %s regs got %h/%0d want 0/0", nm, time_bcd, err_cnt); end
  endtask

  task automatic test_reset();
    rst = 1'b0; tick = 1'b0; man_sw = 1'b0; clr_err = 1'b0; sev_seg = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    m_have = 0; m_prev = 0; m_cnt = 0; m_sticky = 0;
    repeat (2) @(negedge clk);
    check_idle("post_reset");
  endtask

  task automatic test_sequence();
    run_hms("s_12_34_58", 12, 34, 58, 0, 0);
    run_hms("s_12_34_59", 12, 34, 59, 0, 0);
    run_hms("s_23_59_59", 23, 59, 59, 0, 0);
    run_hms("s_00_00_00", 0, 0, 0, 0, 0);
    run_hms("s_09_59_59", 9, 59, 59, 0, 0);
    run_hms("s_10_00_00", 10, 0, 0, 0, 0);
    run_hms("s_19_59_59", 19, 59, 59, 0, 0);
    run_hms("s_20_00_00", 20, 0, 0, 0, 0);
    run_hms("s_12_00_05", 12, 0, 5, 0, 0);
    run_hms("s_12_00_07", 12, 0, 7, 0, 0);
    run_hms("s_12_00_08", 12, 0, 8, 0, 0);
  endtask

  task automatic test_seg_err();
    int d[6];
    d[5] = 1; d[4] = 2; d[3] = 0; d[2] = 0; d[1] = 1; d[0] = 15;
    run_frame("bad_sec0", d, 0, 0);
    run_hms("after_bad", 12, 0, 30, 0, 0);
    run_hms("hr_24", 24, 0, 0, 0, 0);
    run_hms("min_60", 11, 60, 0, 0, 0);
    run_hms("sec_60", 11, 0, 60, 0, 0);
  endtask

  task automatic test_man_sw();
    run_hms("man_05", 5, 0, 0, 1, 0);
    run_hms("man_22", 22, 58, 58, 1, 0);
    run_hms("rel_a", 7, 15, 30, 0, 0);
    run_hms("rel_b", 7, 15, 31, 0, 0);
    run_hms("rel_c", 7, 15, 33, 0, 0);
  endtask

  task automatic test_saturate();
    int d[6];
    d[5] = 0; d[4] = 1; d[3] = 0; d[2] = 2; d[1] = 0; d[0] = 15;
    run_hms("clr_only", 3, 3, 3, 0, 1);
    for (int i = 0; i < 300; i++) run_frame("sat", d, 0, 0);
    run_frame("clr_with_err", d, 0, 1);
  endtask

  task automatic test_back_to_back();
    int a[6], b[6];
    logic [23:0] eb;
    bit es, eq;
    int pulses;
    secs_digs(3 * 3600 + 3 * 60 + 3, a);
    secs_digs(1 * 3600 + 2 * 60 + 3, b);
    model_frame(b, 0, 0, eb, es, eq);
    pulses = 0;
    @(negedge clk); drive_digs(a); man_sw = 1'b0; tick = 1'b1;
    @(negedge clk); drive_digs(b);
    @(negedge clk); tick = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      if (time_vld === 1'b1) pulses++;
      n_cmp++; if (time_vld !== (k == 4)) begin n_bad++; $display("FAIL b2b vld k=%0d got %b want %b", k, time_vld, (k == 4)); end
      if (k == 4) begin
        n_cmp++; if (time_bcd !== eb) begin n_bad++; $display("FAIL b2b time_bcd got %h want %h", time_bcd, eb); end
      end
      if (k == 5) begin
        n_cmp++; if ({seg_err, seq_err} !== {es, eq}) begin n_bad++; $display("FAIL b2b errs got %b%b want %b%b", seg_err, seq_err, es, eq); end
      end
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL b2b pulse_count got %0d want 1", pulses); end
    n_cmp++; if (err_cnt !== m_cnt[7:0]) begin n_bad++; $display("FAIL b2b err_cnt got %0d want %0d", err_cnt, m_cnt); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); run_hms("pre_rst", 4, 4, 4, 0, 0);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    rst = 1'b0;
    #1 check_idle("mid_reset");
    @(negedge clk); rst = 1'b1;
    m_have = 0; m_cnt = 0; m_sticky = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++; if ({time_vld, seg_err, seq_err} !== 3'b0) begin n_bad++; $display("FAIL after_reset pulse k=%0d got %b want 000", k, {time_vld, seg_err, seq_err}); end
    end
    run_hms("rst_first", 8, 0, 0, 0, 0);
    run_hms("rst_second", 8, 0, 1, 0, 0);
  endtask

  task automatic test_random();
    int d[6];
    int r, s, pos;
    bit man, clr;
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 15);
      if (r < 8 && m_have != 0) s = (m_prev + 1) % 86400;
      else s = $urandom_range(0, 86399);
      secs_digs(s, d);
      if (r == 15) begin pos = $urandom_range(0, 5); d[pos] = 15; end
      if (r == 14) begin d[5] = 2; d[4] = $urandom_range(4, 9); end
      if (r == 12) begin d[1] = $urandom_range(6, 9); end
      man = (r == 13);
      clr = ($urandom_range(0, 19) == 0);
      run_frame("rand", d, man, clr);
    end
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_sequence();
    test_seg_err();
    test_man_sw();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtc_seg_monitor.md
Name: rtc_seg_monitor

Overview:
- Other end of the RTC display path: reads back the six seven-segment digit patterns the RTC display driver produces and decodes them to BCD HH:MM:SS.
- Checks that consecutive 1 Hz samples advance by exactly one second, with wrap at 23:59:59 -> 00:00:00.
- Flags illegal segment patterns and counts errors.
- Sits beside the display driver in the top level; used on-board and as a bench scoreboard.

Parameters:
- SAMPLE_DLY, 2, clock cycles from tick to capture of sev_seg (range 1-15); lets the display settle after a count enable.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous active-low reset
- sev_seg  in  7 x 6 array  segment patterns, active-low, bit order gfedcba; index 5=hr1, 4=hr0, 3=min1, 2=min0, 1=sec1, 0=sec0
- tick  in  1  one-cycle sample request (driver count enable)
- man_sw  in  1  manual-set mode; suppresses sequence checking
- clr_err  in  1  synchronous clear of err_cnt and err_sticky
- time_bcd  out  24  decoded {hr1,hr0,min1,min0,sec1,sec0}, 4 bits each
- time_vld  out  1  one-cycle pulse when time_bcd updates
- seg_err  out  1  one-cycle pulse: frame had an illegal pattern or out-of-range digit
- seq_err  out  1  one-cycle pulse: frame is not previous + 1 s
- err_cnt  out  ERR_W  saturating error count
- err_sticky  out  1  set on any error until clr_err

Behaviour:
- Reset (rst=0, async): all outputs 0, delay counter idle, FSM in EMPTY, previous-time register 0.
- Delay counter:
  - tick loads SAMPLE_DLY; the counter decrements each cycle; capture occurs on the cycle it reaches 0.
  - A tick while a count is pending restarts the count (latest tick wins); no error.
- Pipeline:
  - Capture register at cycle C.
  - Decode register at C+1; time_bcd and time_vld drive at C+1.
  - Check result at C+2; seg_err and seq_err pulse at C+2.
- Decode:
  - Legal active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other pattern decodes to 4'hF and marks the frame bad.
- Range check marks the frame bad when any of these hold:
  - hr1 > 2
  - hr1 = 2 and hr0 > 3
  - min1 > 5
  - sec1 > 5
- A bad frame still produces a time_vld pulse; time_bcd shows the decoded value, with F in illegal digits.
- FSM states:
  - EMPTY: no reference time held.
  - TRACK: previous time held.
- FSM transitions, evaluated on each decoded frame:
  - man_sw=1: -> EMPTY; no check, no error.
  - Bad frame: seg_err=1, error event, -> EMPTY.
  - EMPTY + good frame: store as previous, -> TRACK; no check.
  - TRACK + good frame equal to inc(previous): store, stay in TRACK.
  - TRACK + good frame not equal to inc(previous): seq_err=1, error event, store the received frame (resync), stay in TRACK.
- inc() is BCD ripple:
  - sec0 9->0 carries into sec1; sec1 5->0 carries into min0; minutes follow the same rule.
  - Hours: 09->10, 19->20, 23->00.
- Error event: err_cnt += 1, saturating at 2^ERR_W-1; err_sticky=1.
- clr_err in the same cycle as an error event: the clear applies first, so err_cnt=1 and err_sticky=1.
- man_sw changing mid-pipeline: its level is sampled in the check stage.
- Reset mid-operation aborts the pending capture; no pulses follow.

Decomposition:
- Package rtc_pkg holds:
  - bcd_t (logic [3:0]) and the rtc_time_t packed struct of six bcd_t.
  - The SEG_0..SEG_9 active-low constants.
  - A pure function rtc_inc(rtc_time_t) returning rtc_time_t.
  - A function rtc_in_range(rtc_time_t).
- Sub-module seg7_decode: combinational, 7-bit pattern -> bcd_t plus legal flag; instantiated 6 times.

Test Plan:
- Reset, then frames 12:34:58 then 12:34:59 (SAMPLE_DLY=2) -> time_vld 3 cycles after each tick (capture at tick+2, decode drive at +1); time_bcd=24'h123459; no errors; err_cnt=0.
- Frames 23:59:59 then 00:00:00 -> no seq_err. Frames 09:59:59 then 10:00:00 -> no seq_err.
- Frames 12:00:05 then 12:00:07 -> seq_err pulse, err_cnt=1, err_sticky=1. A following 12:00:08 -> no error (resync).
- Digit sec0 pattern 1111111 -> seg_err, time_bcd[3:0]=4'hF, err_cnt increments. Next good frame is accepted without a check. Frame 24:00:00 -> seg_err.
- man_sw=1 with frames 05:00:00 then 22:58:58 -> no errors. Release man_sw; next two consecutive frames are checked normally.
- Force 300 errors -> err_cnt=255. clr_err together with an error -> err_cnt=1. Two ticks 1 cycle apart -> single capture 2 cycles after the second tick.
